// File: rtl/runner_sprite_draw_pkg.sv
// Shared definitions for the runner sprite renderer.
// Holds the frame-buffer geometry, the 3-bit colour palette and the
// draw-sequencer state encoding used by runner_sprite_draw.
package runner_sprite_draw_pkg;

    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_ERASE = 3'd2,
        ST_DRAW  = 3'd3,
        ST_DONE  = 3'd4
    } draw_state_e;

endpackage

// File: rtl/runner_sprite_draw_sprite_scanner.sv
// Row-major column/row counter over an SPR_W x SPR_H box.
// Ports:
//   clk, resetn : clock and asynchronous active-low reset
//   start       : synchronously returns the scan to (0,0)
//   enable      : advance one pixel; wraps to (0,0) after the last pixel
//   col, row    : pixel index that will be emitted on the next advance
//   last        : current index is the final pixel of the box
module runner_sprite_draw_sprite_scanner
    import runner_sprite_draw_pkg::*;
#(
    parameter int SPR_W = 4,
    parameter int SPR_H = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       enable,
    output logic [3:0] col,
    output logic [3:0] row,
    output logic       last
);

    logic [3:0] col_q, col_d;
    logic [3:0] row_q, row_d;
    logic       col_end_s;
    logic       row_end_s;

    assign col_end_s = (col_q == 4'(SPR_W - 1));
    assign row_end_s = (row_q == 4'(SPR_H - 1));

    // Next scan index: clear on start, else step column then row, wrapping.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start) begin
            col_d = 4'd0;
            row_d = 4'd0;
        end else if (enable) begin
            if (col_end_s) begin
                col_d = 4'd0;
                if (row_end_s) begin
                    row_d = 4'd0;
                end else begin
                    row_d = row_q + 4'd1;
                end
            end else begin
                col_d = col_q + 4'd1;
            end
        end else begin
            col_d = col_q;
        end
    end

    // Scan counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_q <= 4'd0;
            row_q <= 4'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign last = col_end_s && row_end_s;

endmodule

// File: rtl/runner_sprite_draw.sv
// Runner sprite renderer: on each update edge, erases the box at the last
// drawn position (if any) and draws it at the newly latched position,
// emitting one pixel per clock to the VGA frame-buffer adapter.
// Ports:
//   clk, resetn        : clock and asynchronous active-low reset
//   update             : frame tick; a rising edge starts a frame
//   x_in, y_in         : runner top-left position, sampled in LATCH
//   vga_x, vga_y       : pixel address (valid while plot is high)
//   vga_colour, plot   : pixel colour and write enable
//   busy               : high from LATCH through DONE
//   frame_done         : one-cycle pulse in DONE
//   overrun            : sticky, an update edge arrived while busy
module runner_sprite_draw
    import runner_sprite_draw_pkg::*;
#(
    parameter int         SPR_W     = 4,
    parameter int         SPR_H     = 8,
    parameter logic [2:0] FG_COLOUR = WHITE,
    parameter logic [2:0] BG_COLOUR = BLACK
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       update,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    draw_state_e state_q, state_d;
    logic       update_d_q;
    logic       rise_s;
    logic [7:0] new_x_q, new_x_d, old_x_q, old_x_d;
    logic [6:0] new_y_q, new_y_d, old_y_q, old_y_d;
    logic       old_valid_q, old_valid_d;
    logic       shown_last_q, shown_last_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
    logic       overrun_q, overrun_d;

    logic       scan_start_s;
    logic       scan_en_s;
    logic [3:0] scan_col_s;
    logic [3:0] scan_row_s;
    logic       scan_last_s;
    logic [7:0] base_x_s;
    logic [6:0] base_y_s;
    logic [8:0] col_sum_s;
    logic [7:0] row_sum_s;

    assign rise_s = update && !update_d_q;

    // The scanner index always names the pixel about to be emitted, so it
    // is parked at (0,0) while idle and wraps naturally from ERASE to DRAW.
    assign scan_start_s = (state_q == ST_IDLE);

    runner_sprite_draw_sprite_scanner #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_scanner (
        .clk    (clk),
        .resetn (resetn),
        .start  (scan_start_s),
        .enable (scan_en_s),
        .col    (scan_col_s),
        .row    (scan_row_s),
        .last   (scan_last_s)
    );

    // Sequencer next state and bookkeeping of latched/previous positions.
    always_comb begin
        state_d     = state_q;
        new_x_d     = new_x_q;
        new_y_d     = new_y_q;
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
        old_valid_d = old_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LATCH: begin
                new_x_d = x_in;
                new_y_d = y_in;
                if (old_valid_q) begin
                    state_d = ST_ERASE;
                end else begin
                    state_d = ST_DRAW;
                end
            end
            ST_ERASE: begin
                if (shown_last_q) begin
                    state_d = ST_DRAW;
                end else begin
                    state_d = ST_ERASE;
                end
            end
            ST_DRAW: begin
                if (shown_last_q) begin
                    state_d     = ST_DONE;
                    old_x_d     = new_x_q;
                    old_y_d     = new_y_q;
                    old_valid_d = 1'b1;
                end else begin
                    state_d = ST_DRAW;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so a registered pixel shows
    // up in the very cycle its scan phase is active.
    always_comb begin
        scan_en_s = (state_d == ST_ERASE) || (state_d == ST_DRAW);
        if (state_d == ST_ERASE) begin
            base_x_s = old_x_q;
            base_y_s = old_y_q;
        end else begin
            base_x_s = new_x_d;
            base_y_s = new_y_d;
        end
        col_sum_s    = {1'b0, base_x_s} + {5'b00000, scan_col_s};
        row_sum_s    = {1'b0, base_y_s} + {4'b0000, scan_row_s};
        shown_last_d = scan_en_s && scan_last_s;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        plot_d       = 1'b0;
        if (scan_en_s) begin
            vga_x_d      = col_sum_s[7:0];
            vga_y_d      = row_sum_s[6:0];
            vga_colour_d = (state_d == ST_ERASE) ? BG_COLOUR : FG_COLOUR;
            plot_d       = (col_sum_s < 9'(SCR_W)) && (row_sum_s < 8'(SCR_H));
        end else begin
            plot_d = 1'b0;
        end
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_DONE);
        // Any edge outside IDLE (DONE included) is dropped and remembered.
        overrun_d    = overrun_q || (rise_s && (state_q != ST_IDLE));
    end

    // State, position and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            update_d_q   <= 1'b0;
            new_x_q      <= 8'd0;
            new_y_q      <= 7'd0;
            old_x_q      <= 8'd0;
            old_y_q      <= 7'd0;
            old_valid_q  <= 1'b0;
            shown_last_q <= 1'b0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= BG_COLOUR;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            update_d_q   <= update;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            old_x_q      <= old_x_d;
            old_y_q      <= old_y_d;
            old_valid_q  <= old_valid_d;
            shown_last_q <= shown_last_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_runner_sprite_draw.sv
// Self-checking bench for runner_sprite_draw: a frame-level reference model
// predicts every output each cycle; directed frames pin the model with
// literal pixel counts and positions; random frames stress latching,
// clipping and overrun handling.
module tb_runner_sprite_draw;

    localparam int W  = 4;
    localparam int H  = 8;
    localparam int N  = W * H;
    localparam int FG = 7;
    localparam int BG = 0;

    logic       clk = 1'b0;
    logic       resetn;
    logic       update;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    runner_sprite_draw dut (
        .clk        (clk),
        .resetn     (resetn),
        .update     (update),
        .x_in       (x_in),
        .y_in       (y_in),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a frame is a sequence of cycles t = 0 .. len-1
    // (latch, optional N erase pixels, N draw pixels, done).
    bit m_in, m_erase, m_ov, m_overrun, m_upd_last;
    int m_t, m_len, m_ox, m_oy, m_nx, m_ny;

    // Observed-frame statistics for literal checks.
    int busy_run = 0, plot_run = 0, last_busy_len = 0, last_plot = 0;
    int first_x = 0, first_y = 0, first_c = 0, done_cnt = 0;
    bit prev_busy = 1'b0;
    int cur_x = 0, cur_y = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_in = 0; m_erase = 0; m_ov = 0; m_overrun = 0; m_upd_last = 0;
        m_t = 0; m_len = 0; m_ox = 0; m_oy = 0; m_nx = 0; m_ny = 0;
    endtask

    // Advance the model across the coming clock edge using current inputs.
    task automatic model_step();
        bit rise;
        if (!resetn) begin
            model_reset();
        end else begin
            rise = update && !m_upd_last;
            m_upd_last = update;
            if (m_in) begin
                if (rise) m_overrun = 1;
                if (m_t == 0) begin
                    m_nx = int'(x_in);
                    m_ny = int'(y_in);
                end
                if (m_t == m_len - 1) begin
                    m_in = 0; m_ox = m_nx; m_oy = m_ny; m_ov = 1;
                end else begin
                    m_t++;
                end
            end else if (rise) begin
                m_in = 1; m_t = 0; m_erase = m_ov;
                m_len = m_ov ? 2 + 2 * N : 2 + N;
            end
        end
    endtask

    // Compare process: check every output each cycle, then gather statistics.
    always @(negedge clk) begin : cmp_p
        int p, q, bx, by, col, row, ecol;
        bit scan, eplot;
        scan  = m_in && (m_t >= 1) && (m_t <= m_len - 2);
        p     = m_t - 1;
        bx = 0; by = 0; col = 0; row = 0; ecol = 0;
        if (scan) begin
            if (m_erase && p < N) begin
                q = p; bx = m_ox; by = m_oy; ecol = BG;
            end else begin
                q = m_erase ? p - N : p; bx = m_nx; by = m_ny; ecol = FG;
            end
            col = q % W;
            row = q / W;
        end
        eplot = scan && (bx + col < 160) && (by + row < 120);
        chk("plot", 32'(plot), 32'(eplot));
        chk("busy", 32'(busy), 32'(m_in));
        chk("frame_done", 32'(frame_done), 32'(m_in && (m_t == m_len - 1)));
        chk("overrun", 32'(overrun), 32'(m_overrun));
        if (scan) chk("colour", 32'(vga_colour), 32'(ecol));
        if (eplot) begin
            chk("vga_x", 32'(vga_x), 32'(bx + col));
            chk("vga_y", 32'(vga_y), 32'(by + row));
        end
        if (busy) begin
            busy_run++;
            if (plot) begin
                if (plot_run == 0) begin
                    first_x = int'(vga_x); first_y = int'(vga_y); first_c = int'(vga_colour);
                end
                plot_run++;
            end
        end else if (prev_busy) begin
            last_busy_len = busy_run; last_plot = plot_run;
            busy_run = 0; plot_run = 0;
        end
        if (frame_done) done_cnt++;
        prev_busy = busy;
    end

    task automatic cyc(input bit u, input int x, input int y);
        @(negedge clk);
        #2;
        update = u;
        x_in   = 8'(x);
        y_in   = 7'(y);
        model_step();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, cur_x, cur_y);
    endtask

    task automatic pulse(input int x, input int y);
        cur_x = x; cur_y = y;
        cyc(1'b1, x, y);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        update = 1'b0;
        #1;
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_vga_x", 32'(vga_x), 32'd0);
        chk("rst_vga_y", 32'(vga_y), 32'd0);
        chk("rst_colour", 32'(vga_colour), 32'(BG));
        model_reset();
        idle(n);
        @(negedge clk);
        #2;
        resetn = 1'b1;
        model_step();
    endtask

    initial begin
        int d0, gap;
        resetn = 1'b0; update = 1'b0; x_in = 8'd0; y_in = 7'd0;
        model_reset();
        idle(3);
        @(negedge clk);
        #2;
        resetn = 1'b1;
        model_step();
        idle(2);

        // First frame: draw only.
        pulse(20, 108); idle(45);
        chk("f1_busy_len", 32'(last_busy_len), 32'd34);
        chk("f1_plots", 32'(last_plot), 32'd32);
        chk("f1_first_x", 32'(first_x), 32'd20);
        chk("f1_first_y", 32'(first_y), 32'd108);
        chk("f1_first_c", 32'(first_c), 32'd7);

        // Second frame: erase old box, draw new one.
        pulse(20, 99); idle(75);
        chk("f2_busy_len", 32'(last_busy_len), 32'd66);
        chk("f2_plots", 32'(last_plot), 32'd64);
        chk("f2_first_x", 32'(first_x), 32'd20);
        chk("f2_first_y", 32'(first_y), 32'd108);
        chk("f2_first_c", 32'(first_c), 32'd0);

        // Clipping at the bottom-right corner.
        pulse(158, 116); idle(75);
        chk("clip_busy_len", 32'(last_busy_len), 32'd66);
        chk("clip_plots", 32'(last_plot), 32'd40);

        // Update held high: a single frame, no overrun.
        do_reset(2);
        d0 = done_cnt;
        cur_x = 50; cur_y = 50;
        repeat (200) cyc(1'b1, 50, 50);
        idle(5);
        chk("hold_frames", 32'(done_cnt - d0), 32'd1);
        chk("hold_busy_len", 32'(last_busy_len), 32'd34);
        chk("hold_overrun", 32'(overrun), 32'd0);

        // Update edge mid-ERASE is ignored but flagged.
        pulse(60, 30); idle(11);
        cyc(1'b1, 100, 5);
        idle(70);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_busy_len", 32'(last_busy_len), 32'd66);
        pulse(61, 31); idle(75);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of DRAW; next frame must skip ERASE.
        pulse(70, 40); idle(40);
        do_reset(2);
        pulse(70, 40); idle(45);
        chk("post_rst_busy_len", 32'(last_busy_len), 32'd34);
        chk("post_rst_plots", 32'(last_plot), 32'd32);

        // Random frames with random positions, noise on x/y, stray updates.
        for (int f = 0; f < 25; f++) begin
            cur_x = int'($urandom_range(0, 255));
            cur_y = int'($urandom_range(0, 127));
            repeat ($urandom_range(1, 3)) cyc(1'b1, cur_x, cur_y);
            gap = int'($urandom_range(20, 90));
            for (int i = 0; i < gap; i++) begin
                cyc($urandom_range(0, 24) == 0, int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 127)));
            end
        end
        idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
